// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter for the shared broadcast bus fed by DRVRS driver FIFOs.
//   Grants the bus to one requesting driver at a time. The grant is held until
//   the owner releases it (rls pulse or dropping its request) or until MAX_HOLD
//   cycles expire. A one-cycle turnaround gap (gnt=0) separates owners.
//
//   Handshake: req is a level held by a driver until it has been served.
//   rls is a 1-cycle pulse from the current owner and only has an effect in
//   BUSY. gnt, gnt_valid and gnt_id are registered and change only on posedge.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   en         arbitration enable; 0 blocks new grants only
//   req        per-driver request level
//   rls        release pulse from the current owner
//   gnt        one-hot grant (registered)
//   gnt_valid  |gnt (registered)
//   gnt_id     binary index of owner, 0 when no grant
//   timeout    1-cycle pulse when a grant is revoked by hold-limit expiry
//   dbg_state  current FSM state (IDLE=0, BUSY=1, GAP=2) for observation
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int DRVRS    = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DRVRS-1:0] req,
  input  logic             rls,
  output logic [DRVRS-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  localparam int HCW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q;
  logic [DRVRS-1:0]   gnt_q;
  logic               gnt_valid_q;
  logic [IDW-1:0]     gnt_id_q;
  logic               timeout_q;
  logic [HCW-1:0]     hold_cnt_q;
  logic [IDW-1:0]     last_q;

  // Winner search: starts just after the previous owner and wraps, so the
  // previous owner is the last candidate considered.
  logic               win_found;
  logic [IDW-1:0]     win_id;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(last_q) + k) % DRVRS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  logic owner_release;
  logic hold_expired;

  // Explicit rls and a dropped request both count as release and take
  // priority over expiry, so a coinciding expiry gives no timeout pulse.
  assign owner_release = rls || !req[gnt_id_q];
  assign hold_expired  = (hold_cnt_q == HCW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= IDW'(DRVRS - 1);
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (en && win_found) begin
            gnt_q       <= {{(DRVRS-1){1'b0}}, 1'b1} << win_id;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= win_id;
            hold_cnt_q  <= '0;
            state_q     <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (owner_release || hold_expired) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            last_q      <= gnt_id_q;
            timeout_q   <= !owner_release;
            state_q     <= GAP;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
          gnt_id_q    <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Directed bench for bus_rr_arbiter (DRVRS=4, MAX_HOLD=16). Each step drives
//   inputs, pushes the expected post-edge outputs {gnt, gnt_valid, gnt_id,
//   timeout} into exp_q, waits for the edge and compares against the popped
//   entry.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int DRVRS    = 4;
  localparam int MAX_HOLD = 16;
  localparam int IDW      = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             en;
  logic [DRVRS-1:0] req;
  logic             rls;
  logic [DRVRS-1:0] gnt;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic             timeout;
  logic [1:0]       dbg_state;

  bus_rr_arbiter #(
    .DRVRS   (DRVRS),
    .MAX_HOLD(MAX_HOLD),
    .IDW     (IDW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .req      (req),
    .rls      (rls),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [7:0] mk_exp(input logic [3:0] g, input logic t);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) id = 2'(i);
    return {g, |g, id, t};
  endfunction

  task automatic check(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {gnt, gnt_valid, gnt_id, timeout};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h with empty expected queue", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed {gnt,v,id,to}=%b expected %b", tag, obs, exp);
      end
    end
  endtask

  // driver: apply inputs, push expectation, clock, compare #1 after the edge
  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic l, input logic [3:0] eg, input logic et,
                      input string tag);
    reset = r;
    en    = e;
    req   = rq;
    rls   = l;
    exp_q.push_back(mk_exp(eg, et));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  int rot[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;
    rls   = 1'b0;
    #1;

    // 1. reset held with all requests
    step(1, 1, 4'b1111, 0, 4'b0000, 0, "reset0");
    step(1, 1, 4'b1111, 0, 4'b0000, 0, "reset1");

    // 2. rotation 0,1,2,3,0 with rls 3 cycles after each grant
    for (int n = 0; n < 5; n++) begin
      logic [3:0] g;
      g = 4'b0001 << rot[n];
      step(0, 1, 4'b1111, 0, g, 0, "rot_grant");
      step(0, 1, 4'b1111, 0, g, 0, "rot_hold1");
      step(0, 1, 4'b1111, 0, g, 0, "rot_hold2");
      step(0, 1, 4'b1111, 1, 4'b0000, 0, "rot_gap");
    end

    // 3. timeout: lone requester 2 held 16 cycles, then forced release
    step(0, 1, 4'b0100, 0, 4'b0100, 0, "to_grant");
    for (int n = 0; n < MAX_HOLD - 1; n++)
      step(0, 1, 4'b0100, 0, 4'b0100, 0, "to_hold");
    step(0, 1, 4'b0100, 0, 4'b0000, 1, "to_pulse");
    step(0, 1, 4'b0100, 0, 4'b0100, 0, "to_regrant");

    // 4. implicit release and wrap-around
    step(0, 1, 4'b1000, 0, 4'b0000, 0, "impl_rel2");
    step(0, 1, 4'b1000, 0, 4'b1000, 0, "grant3");
    step(0, 1, 4'b1000, 0, 4'b1000, 0, "hold3");
    step(0, 1, 4'b0011, 0, 4'b0000, 0, "impl_rel3");
    step(0, 1, 4'b0011, 0, 4'b0001, 0, "wrap_to0");
    step(0, 1, 4'b0011, 1, 4'b0000, 0, "rel0");
    step(0, 1, 4'b0000, 0, 4'b0000, 0, "to_idle");

    // 5a. enable gating
    step(0, 0, 4'b0010, 0, 4'b0000, 0, "en0_a");
    step(0, 0, 4'b0010, 1, 4'b0000, 0, "en0_rls_idle");
    step(0, 1, 4'b0010, 0, 4'b0010, 0, "en1_grant");

    // 5b. en=0 during BUSY keeps the grant; rls coinciding with expiry
    for (int n = 0; n < MAX_HOLD - 1; n++)
      step(0, 0, 4'b0010, 0, 4'b0010, 0, "busy_en0");
    step(0, 0, 4'b0010, 1, 4'b0000, 0, "rls_at_expiry");
    step(0, 1, 4'b0010, 0, 4'b0010, 0, "lone_regrant");

    // 6. reset mid-BUSY at hold_cnt=5
    for (int n = 0; n < 5; n++)
      step(0, 1, 4'b0010, 0, 4'b0010, 0, "pre_reset_hold");
    step(1, 1, 4'b1111, 0, 4'b0000, 0, "mid_reset");
    step(0, 1, 4'b1111, 0, 4'b0001, 0, "post_reset_grant0");

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
